// File: rtl/dpwm_carrier_ctrl.sv
// Triangular carrier, 180-degree shifted complement and valley-synchronous
// duty / carrier-select scheduling for one FCML phase comparator bank.
module dpwm_carrier_ctrl #(
    parameter int PERIOD = 1000,
    parameter int NCELL  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [10:0]      duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic [NCELL-1:0] shflag_cfg,
    input  logic             rot_en,
    output logic [10:0]      ramp_ref,
    output logic [10:0]      ramp_ref_s,
    output logic [NCELL-1:0] shflag,
    output logic [10:0]      dpwm_duty,
    output logic             valley,
    output logic             running
);
    localparam int W = 11;
    localparam logic [W-1:0] LP_PERIOD = W'(PERIOD);
    localparam logic [W-1:0] LP_TOP    = W'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt;
    logic [W-1:0]     r_shadow, w_shadow_nxt;
    logic             r_pending, w_pending_nxt;
    logic [W-1:0]     r_duty, w_duty_nxt;
    logic [NCELL-1:0] r_shflag, w_shflag_nxt;
    logic             w_start, w_turn, w_vl, w_to_idle, w_accept;

    function automatic logic [W-1:0] sat_period(input logic [W-1:0] d);
        return (d > LP_PERIOD) ? LP_PERIOD : d;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_turn marks the edge on which the down-slope reaches the valley
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_to_idle   = 1'b0;
        w_turn      = r_dir && (r_cnt == W'(1));
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                    w_start     = 1'b1;
                end
            end
            RUN: begin
                if (!en) w_state_nxt = STOP;
            end
            STOP: begin
                if (en) begin
                    w_state_nxt = RUN;
                end else if (w_turn) begin
                    w_state_nxt = IDLE;
                    w_to_idle   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_vl = w_start || ((r_state != IDLE) && w_turn);
    end

    always_comb begin
        w_cnt_nxt = '0;
        w_dir_nxt = 1'b0;
        if (r_state != IDLE) begin
            if (!r_dir) begin
                w_cnt_nxt = r_cnt + W'(1);
                w_dir_nxt = (r_cnt == LP_TOP);
            end else begin
                w_cnt_nxt = r_cnt - W'(1);
                w_dir_nxt = !w_turn;
            end
        end
    end

    // A valley load sees the pre-edge pending flag, so a same-edge accept waits one period
    always_comb begin
        w_accept      = duty_valid && !r_pending;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_duty_nxt    = r_duty;
        w_shflag_nxt  = r_shflag;
        if (w_to_idle) begin
            w_duty_nxt   = '0;
            w_shflag_nxt = '0;
        end else if (w_vl) begin
            if (r_pending) begin
                w_duty_nxt    = r_shadow;
                w_pending_nxt = 1'b0;
            end
            w_shflag_nxt = (rot_en && !w_start) ? {r_shflag[NCELL-2:0], r_shflag[NCELL-1]}
                                                : shflag_cfg;
        end
        if (w_accept) begin
            w_shadow_nxt  = sat_period(duty_in);
            w_pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_duty    <= '0;
            r_shflag  <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_duty    <= w_duty_nxt;
            r_shflag  <= w_shflag_nxt;
        end
    end

    assign ramp_ref   = r_cnt;
    assign ramp_ref_s = LP_PERIOD - r_cnt;
    assign running    = (r_state != IDLE);
    assign valley     = running && (r_cnt == '0);
    assign duty_ready = !r_pending;
    assign dpwm_duty  = r_duty;
    assign shflag     = r_shflag;

endmodule

// File: tb/tb_dpwm_carrier_ctrl.sv
// Bench for dpwm_carrier_ctrl at PERIOD=8, NCELL=4: a phase-based carrier model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dpwm_carrier_ctrl;
    localparam int P  = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [10:0]   duty_in = '0;
    logic          duty_valid = 1'b0;
    logic [NC-1:0] shflag_cfg = '0;
    logic          rot_en = 1'b0;
    logic          duty_ready;
    logic [10:0]   ramp_ref;
    logic [10:0]   ramp_ref_s;
    logic [NC-1:0] shflag;
    logic [10:0]   dpwm_duty;
    logic          valley;
    logic          running;

    dpwm_carrier_ctrl #(.PERIOD(P), .NCELL(NC)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .shflag_cfg (shflag_cfg),
        .rot_en     (rot_en),
        .ramp_ref   (ramp_ref),
        .ramp_ref_s (ramp_ref_s),
        .shflag     (shflag),
        .dpwm_duty  (dpwm_duty),
        .valley     (valley),
        .running    (running)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: the carrier is a position m_t within the 2P-clock period
    int            m_t = 0;
    bit            m_run = 0, m_stp = 0, m_pend = 0;
    int            m_shadow = 0, m_duty = 0;
    logic [NC-1:0] m_sh = '0;
    bit            m_vl, m_start, m_idle, m_acc;

    function automatic int tri_of(input int t);
        return (t <= P) ? t : 2 * P - t;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t = 0; m_run = 0; m_stp = 0; m_pend = 0;
            m_shadow = 0; m_duty = 0; m_sh = '0;
        end else begin
            m_vl = 0; m_start = 0; m_idle = 0;
            m_acc = duty_valid && !m_pend;
            if (!m_run) begin
                m_t = 0;
                if (en) begin m_run = 1; m_start = 1; m_vl = 1; end
            end else begin
                m_t = (m_t + 1) % (2 * P);
                if (m_t == 0) m_vl = 1;
                if (m_stp) begin
                    if (en) m_stp = 0;
                    else if (m_vl) begin m_idle = 1; m_run = 0; m_stp = 0; end
                end else if (!en) begin
                    m_stp = 1;
                end
            end
            if (m_idle) begin
                m_duty = 0;
                m_sh   = '0;
            end else if (m_vl) begin
                if (m_pend) begin m_duty = m_shadow; m_pend = 0; end
                if (rot_en && !m_start) m_sh = (m_sh << 1) | (m_sh >> (NC - 1));
                else m_sh = shflag_cfg;
            end
            if (m_acc) begin
                m_shadow = (int'(duty_in) > P) ? P : int'(duty_in);
                m_pend   = 1;
            end
        end
    end

    always @(posedge clk) begin
        int er;
        #1;
        er = m_run ? tri_of(m_t) : 0;
        chk("m_ramp_ref",   int'(ramp_ref),   er);
        chk("m_ramp_ref_s", int'(ramp_ref_s), P - er);
        chk("m_valley",     int'(valley),     (m_run && er == 0) ? 1 : 0);
        chk("m_running",    int'(running),    m_run ? 1 : 0);
        chk("m_duty_ready", int'(duty_ready), m_pend ? 0 : 1);
        chk("m_dpwm_duty",  int'(dpwm_duty),  m_duty);
        chk("m_shflag",     int'(shflag),     int'(m_sh));
    end

    task automatic wait_ramp(input int target, input bit up, input string nm);
        int prev;
        bit hit;
        hit  = 0;
        prev = int'(ramp_ref);
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (int'(ramp_ref) == target &&
                ((up && prev == target - 1) || (!up && prev == target + 1))) hit = 1;
            prev = int'(ramp_ref);
        end
        if (!hit) chk(nm, 0, 1);
    endtask

    task automatic wait_valley(input string nm);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (valley) hit = 1;
        end
        if (!hit) chk(nm, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp17[17];
        int rot3[3];
        int vcnt;
        int n;
        exp17 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        rot3  = '{4'b0110, 4'b1100, 4'b1001};

        // Reset with random inputs
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en         = 1'($urandom);
            duty_valid = 1'($urandom);
            duty_in    = 11'($urandom_range(0, 2047));
            shflag_cfg = NC'($urandom);
            rot_en     = 1'($urandom);
        end
        chk("rst_ramp_ref",   int'(ramp_ref),   0);
        chk("rst_ramp_ref_s", int'(ramp_ref_s), P);
        chk("rst_dpwm_duty",  int'(dpwm_duty),  0);
        chk("rst_shflag",     int'(shflag),     0);
        chk("rst_duty_ready", int'(duty_ready), 1);
        chk("rst_running",    int'(running),    0);
        en = 0; duty_valid = 0; duty_in = '0; rot_en = 0; shflag_cfg = 4'b0011;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Carrier shape
        en   = 1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 17) begin
                chk("shape_ramp",   int'(ramp_ref),   exp17[i]);
                chk("shape_ramp_s", int'(ramp_ref_s), P - exp17[i]);
            end
            if (i == 0) chk("start_shflag", int'(shflag), 4'b0011);
            if (valley) begin
                vcnt++;
                chk("valley_pos", i % 16, 0);
            end
        end
        chk("valley_cnt", vcnt, 3);

        // Rotation at successive valleys
        rot_en = 1;
        for (int k = 0; k < 3; k++) begin
            wait_valley("rot_timeout");
            chk("rot_shflag", int'(shflag), rot3[k]);
        end
        rot_en = 0;

        // Handshake mid up-slope, second valid held off while pending
        wait_ramp(3, 1'b1, "hs_timeout");
        duty_in = 11'd5; duty_valid = 1;
        @(negedge clk);
        chk("hs_ready_drop", int'(duty_ready), 0);
        chk("hs_duty_before", int'(dpwm_duty), 0);
        duty_in = 11'd2;
        wait_valley("hs_valley_timeout");
        chk("hs_duty_applied", int'(dpwm_duty), 5);
        chk("hs_ready_back", int'(duty_ready), 1);
        duty_valid = 0;
        @(negedge clk);
        chk("hs_holdoff_ready", int'(duty_ready), 1);
        chk("hs_holdoff_duty", int'(dpwm_duty), 5);

        // Saturation
        wait_ramp(2, 1'b1, "sat_timeout");
        duty_in = 11'd2000; duty_valid = 1;
        @(negedge clk);
        duty_valid = 0;
        wait_valley("sat_valley_timeout");
        chk("sat_duty", int'(dpwm_duty), P);

        // Accept on a valley-load edge
        wait_ramp(1, 1'b0, "vlacc_timeout");
        duty_in = 11'd3; duty_valid = 1;
        @(negedge clk);
        duty_valid = 0;
        chk("vlacc_valley", int'(valley), 1);
        chk("vlacc_ready", int'(duty_ready), 0);
        chk("vlacc_duty_old", int'(dpwm_duty), P);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (int'(dpwm_duty) == 3) begin n = i; break; end
        end
        chk("vlacc_latency", n, 16);

        // Stop at ramp 5 up-slope, with a duty accepted during STOP
        wait_ramp(5, 1'b1, "stop_timeout");
        en = 0; duty_in = 11'd4; duty_valid = 1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            duty_valid = 0;
            if (!running) begin n = i; break; end
        end
        chk("stop_cycles", n, 11);
        chk("stop_ramp", int'(ramp_ref), 0);
        chk("stop_valley", int'(valley), 0);
        chk("stop_duty", int'(dpwm_duty), 0);
        chk("stop_shflag", int'(shflag), 0);
        chk("stop_pending_kept", int'(duty_ready), 0);
        @(negedge clk);
        @(negedge clk);
        en = 1;
        @(negedge clk);
        chk("restart_running", int'(running), 1);
        chk("restart_valley", int'(valley), 1);
        chk("restart_duty", int'(dpwm_duty), 4);
        chk("restart_shflag", int'(shflag), 4'b0011);
        chk("restart_ready", int'(duty_ready), 1);
        @(negedge clk);
        chk("restart_ramp1", int'(ramp_ref), 1);

        // Re-raise en during STOP
        wait_ramp(5, 1'b1, "reraise_timeout");
        en = 0;
        @(negedge clk);
        @(negedge clk);
        en = 1;
        wait_valley("reraise_valley_timeout");
        chk("reraise_running", int'(running), 1);

        // Asynchronous reset mid-run with a pending shadow
        wait_ramp(3, 1'b1, "ar_timeout");
        duty_in = 11'd6; duty_valid = 1;
        @(negedge clk);
        duty_valid = 0;
        chk("ar_pending", int'(duty_ready), 0);
        wait_ramp(P - 2, 1'b1, "ar_ramp_timeout");
        #2 rst = 1'b0;
        #1;
        chk("ar_ramp", int'(ramp_ref), 0);
        chk("ar_ramp_s", int'(ramp_ref_s), P);
        chk("ar_ready", int'(duty_ready), 1);
        chk("ar_duty", int'(dpwm_duty), 0);
        chk("ar_shflag", int'(shflag), 0);
        chk("ar_running", int'(running), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_restart_running", int'(running), 1);
        chk("ar_restart_ramp0", int'(ramp_ref), 0);
        chk("ar_restart_duty", int'(dpwm_duty), 0);
        @(negedge clk);
        chk("ar_restart_ramp1", int'(ramp_ref), 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
